jtag_host_link: RTL and testbench
=================================

Name: jtag_host_link

Overview:
- Host-side master for the byte-serial JTAG link: generates TCK/TCS/TDI and samples TDO.
- Accepts bytes on a ready/start handshake and shifts each one out LSB-first on TDI. Simultaneously captures 8 TDO bits into a received byte (full duplex).
- Used on-board as the far-end driver for the FPGA-side JTAG byte link, for self-test and host emulation.

Parameters:
- CLK_DIV, 4, TCK half-period in iCLK cycles (H); legal range >=2.
- CS_GAP, 2, minimum iCLK cycles TCS stays high between transfers; >=1.

Ports:
- iCLK  in  1  system clock; all logic on rising edge.
- iRST_n  in  1  asynchronous active-low reset.
- iTxD_DATA  in  8  byte to send; sampled only on the accept cycle.
- iTxD_Start  in  1  request; accepted when iTxD_Start && oTxD_Ready.
- oTxD_Ready  out  1  block can accept a byte this cycle.
- oTxD_Done  out  1  one-cycle pulse at end of each byte.
- oRxD_DATA  out  8  byte captured from TDO; held until next capture.
- oRxD_Ready  out  1  one-cycle pulse, coincident with oTxD_Done, when oRxD_DATA updates.
- TCK  out  1  JTAG clock, registered.
- TCS  out  1  chip select, active-low framing, registered.
- TDI  out  1  serial data to device, registered.
- TDO  in  1  serial data from device.

Behaviour:
- Reset (async, any state): state IDLE, TCS=1, TCK=0, TDI=0, oTxD_Done=0, oRxD_Ready=0, oRxD_DATA=0, bit counter 0, GAP satisfied.
- oTxD_Ready is decoded from the registered state: 1 in IDLE and END, else 0. Its reset value is 1.
- FSM states: IDLE, SETUP, HIGH, LOW, END, GAP.
- IDLE: TCS=1, TCK=0. On accept, at the next clock: latch iTxD_DATA into shift register, TCS<=0, TDI<=bit0, bit counter<=0, go to SETUP.
- SETUP: TCK=0 for H cycles, then TCK<=1 and go to HIGH.
- HIGH: TCK=1 for H cycles. On the last cycle, sample TDO into rx shift register (LSB-first: rx <= {TDO, rx[7:1]}).
  - If bit counter != 7: TCK<=0, TDI<=next bit, counter+1, go to LOW.
  - Otherwise: TCK<=0, go to END.
- LOW: TCK=0 for H cycles, then TCK<=1 and go to HIGH.
- END: single cycle. oTxD_Done=1 and oRxD_Ready=1; oRxD_DATA shows the captured byte from this cycle on.
  - If iTxD_Start=1: accept the next byte and keep TCS=0 (back-to-back); TDI<=bit0, go to SETUP.
  - Otherwise: TCS<=1, TDI<=0, go to GAP.
- GAP: TCS=1 for CS_GAP cycles, then go to IDLE. iTxD_Start is ignored in GAP.
- Latency: with the accept at cycle 0, rising TCK edges occur at cycles H+1+2kH for k=0..7, and END is cycle 16H+1 (65 for the default). Byte period back-to-back is 16H+1 cycles.
- Timing at the device: TDI changes only while TCK=0 and is stable >=H cycles before each rising edge. TDO is sampled H-1 cycles after the rising edge.
- iTxD_Start while oTxD_Ready=0 is ignored with no side effect. iTxD_DATA changes after accept do not affect the byte in flight.
- Reset mid-byte: outputs return to reset values immediately; no oTxD_Done or oRxD_Ready pulse for the aborted byte.

Optional Feature:
- Macro JTAG_HOST_LOOPBACK_EN.
- Defined: adds input port iLoop (1 bit). When iLoop=1, the TDO sample path takes the internal TDI register instead of the TDO pin, so oRxD_DATA equals the transmitted byte. TCK/TCS/TDI still toggle normally.
- Undefined: no iLoop port; TDO is always sampled.

Decomposition:
- Package jtag_host_pkg: FSM state enum, bit-count width constant (3), defaults for CLK_DIV and CS_GAP.
- One sub-module, jtag_half_period_timer: loadable down-counter producing a terminal-count strobe after N cycles. It is reused for the H phases and the CS_GAP phase.

Test Plan:
- Reset held, then released: TCS=1, TCK=0, TDI=0, oTxD_Ready=1, pulses 0; state unchanged for 10 idle cycles.
- Send 0xA5 while the device model returns 0x3C: TDI at the 8 rising TCK edges is 1,0,1,0,0,1,0,1; oTxD_Done and oRxD_Ready pulse at cycle 65; oRxD_DATA=0x3C; TCS high for >=2 cycles after.
- Back-to-back 0x01 then 0x80 with iTxD_Start held: TCS stays low across 16 rising edges; two Done pulses 65 cycles apart; device receives 0x01, 0x80.
- iTxD_Start pulsed with 0xFF during a byte in flight: ignored; TDI pattern of the current byte is unchanged; exactly one Done pulse.
- iRST_n asserted after the 4th rising TCK edge: same-cycle TCS=1, TCK=0, TDI=0; no Done or Ready pulse; next byte 0x55 transfers correctly.
- With JTAG_HOST_LOOPBACK_EN and iLoop=1, send 0x5A while the TDO pin is tied 1: oRxD_DATA=0x5A. With the macro off, the same stimulus gives oRxD_DATA=0xFF.

Source files
------------

// File: rtl/jtag_host_pkg.sv
// -----------------------------------------------------------------------------
// jtag_host_pkg
// Shared types and constants for the host-side JTAG byte-link master.
//   hostState_t  : FSM state encoding
//   BIT_CNT_W    : width of the per-byte bit counter
//   DEFAULT_*    : default TCK half-period and chip-select gap (iCLK cycles)
//   timerWidth() : counter width able to hold the largest timer reload value
// -----------------------------------------------------------------------------
package jtag_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_END,
        ST_GAP
    } hostState_t;

    localparam int unsigned BIT_CNT_W       = 3;
    localparam int unsigned DEFAULT_CLK_DIV = 4;
    localparam int unsigned DEFAULT_CS_GAP  = 2;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(7);

    // Timer reloads with N-1, so the widest value needed is max(CLK_DIV, CS_GAP)-1.
    function automatic int unsigned timerWidth(input int unsigned clkDiv,
                                               input int unsigned csGap);
        int unsigned maxLoad;
        maxLoad = (clkDiv > csGap) ? clkDiv : csGap;
        return (maxLoad < 2) ? 1 : $clog2(maxLoad);
    endfunction

endpackage

// File: rtl/jtag_half_period_timer.sv
// -----------------------------------------------------------------------------
// jtag_half_period_timer
// Loadable down-counter. Loading N-1 makes oTc high during the N-th cycle
// after the load (the last cycle of the phase being timed); oTc stays high
// once the count has reached zero.
// Ports:
//   iCLK, iRST_n : clock, asynchronous active-low reset
//   iLoad        : reload the counter with iLoadVal this cycle
//   iLoadVal     : reload value (phase length minus one)
//   oTc          : registered terminal-count strobe
// -----------------------------------------------------------------------------
module jtag_half_period_timer #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             iCLK,
    input  logic             iRST_n,
    input  logic             iLoad,
    input  logic [WIDTH-1:0] iLoadVal,
    output logic             oTc
);

    logic [WIDTH-1:0] count;

    // oTc is kept equal to (count == 0) one register stage ahead.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            count <= '0;
            oTc   <= 1'b1;
        end else if (iLoad) begin
            count <= iLoadVal;
            oTc   <= (iLoadVal == '0);
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
            oTc   <= (count == WIDTH'(1));
        end
    end

endmodule

// File: rtl/jtag_host_link.sv
// -----------------------------------------------------------------------------
// jtag_host_link
// Host-side master for the byte-serial JTAG link. Each accepted byte is shifted
// out LSB-first on TDI while 8 TDO bits are captured (full duplex). TDI changes
// only while TCK is low; TDO is sampled on the last cycle of each TCK high phase.
// Parameters:
//   CLK_DIV : TCK half-period in iCLK cycles (>= 2)
//   CS_GAP  : minimum iCLK cycles TCS stays high between transfers (>= 1)
// Ports:
//   iCLK, iRST_n : clock, asynchronous active-low reset
//   iTxD_DATA    : byte to send, sampled on the accept cycle
//   iTxD_Start   : send request, accepted when iTxD_Start && oTxD_Ready
//   oTxD_Ready   : a byte can be accepted this cycle (IDLE or END)
//   oTxD_Done    : one-cycle pulse at the end of each byte
//   oRxD_DATA    : byte captured from TDO, held until the next capture
//   oRxD_Ready   : one-cycle pulse when oRxD_DATA updates
//   TCK/TCS/TDI  : registered JTAG clock, active-low select, serial data out
//   TDO          : serial data from the device
//   iLoop        : only with JTAG_HOST_LOOPBACK_EN defined; 1 = capture the
//                  internal TDI register instead of the TDO pin
// Build option: JTAG_HOST_LOOPBACK_EN
// -----------------------------------------------------------------------------
module jtag_host_link
    import jtag_host_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV,
    parameter int unsigned CS_GAP  = DEFAULT_CS_GAP
) (
    input  logic       iCLK,
    input  logic       iRST_n,
    input  logic [7:0] iTxD_DATA,
    input  logic       iTxD_Start,
    output logic       oTxD_Ready,
    output logic       oTxD_Done,
    output logic [7:0] oRxD_DATA,
    output logic       oRxD_Ready,
    output logic       TCK,
    output logic       TCS,
    output logic       TDI,
`ifdef JTAG_HOST_LOOPBACK_EN
    input  logic       iLoop,
`endif
    input  logic       TDO
);

    localparam int unsigned      TMR_W     = timerWidth(CLK_DIV, CS_GAP);
    localparam logic [TMR_W-1:0] HALF_LOAD = TMR_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(CS_GAP - 1);

    hostState_t           state;
    logic [7:0]           txShift;
    logic [7:0]           rxShift;
    logic [7:0]           rxNext;
    logic [BIT_CNT_W-1:0] bitCnt;
    logic                 txAccept;
    logic                 tdoSample;
    logic                 tmrLoad;
    logic [TMR_W-1:0]     tmrLoadVal;
    logic                 tmrTc;

    // Ready is a pure state decode so it is valid in the same cycle as END.
    assign oTxD_Ready = (state == ST_IDLE) || (state == ST_END);
    assign txAccept   = iTxD_Start && oTxD_Ready;

`ifdef JTAG_HOST_LOOPBACK_EN
    assign tdoSample = iLoop ? TDI : TDO;
`else
    assign tdoSample = TDO;
`endif

    assign rxNext = {tdoSample, rxShift[7:1]};

    // Timer reload: every phase change restarts it; leaving END without a new
    // byte times the chip-select gap instead of a TCK half-period.
    always_comb begin
        tmrLoad    = 1'b0;
        tmrLoadVal = HALF_LOAD;
        case (state)
            ST_IDLE:                   tmrLoad = txAccept;
            ST_SETUP, ST_HIGH, ST_LOW: tmrLoad = tmrTc;
            ST_END: begin
                tmrLoad = 1'b1;
                if (!iTxD_Start) begin
                    tmrLoadVal = GAP_LOAD;
                end
            end
            default:                   tmrLoad = 1'b0;
        endcase
    end

    jtag_half_period_timer #(
        .WIDTH (TMR_W)
    ) uPhaseTimer (
        .iCLK     (iCLK),
        .iRST_n   (iRST_n),
        .iLoad    (tmrLoad),
        .iLoadVal (tmrLoadVal),
        .oTc      (tmrTc)
    );

    // Byte-transfer FSM with registered pin and handshake outputs.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state      <= ST_IDLE;
            TCS        <= 1'b1;
            TCK        <= 1'b0;
            TDI        <= 1'b0;
            oTxD_Done  <= 1'b0;
            oRxD_Ready <= 1'b0;
            oRxD_DATA  <= 8'h00;
            bitCnt     <= '0;
            txShift    <= 8'h00;
            rxShift    <= 8'h00;
        end else begin
            oTxD_Done  <= 1'b0;
            oRxD_Ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (txAccept) begin
                        txShift <= {1'b0, iTxD_DATA[7:1]};
                        TDI     <= iTxD_DATA[0];
                        TCS     <= 1'b0;
                        bitCnt  <= '0;
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tmrTc) begin
                        TCK   <= 1'b1;
                        state <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (tmrTc) begin
                        rxShift <= rxNext;
                        TCK     <= 1'b0;
                        if (bitCnt != LAST_BIT) begin
                            TDI     <= txShift[0];
                            txShift <= {1'b0, txShift[7:1]};
                            bitCnt  <= bitCnt + BIT_CNT_W'(1);
                            state   <= ST_LOW;
                        end else begin
                            // Captured byte becomes visible together with Done.
                            oRxD_DATA  <= rxNext;
                            oTxD_Done  <= 1'b1;
                            oRxD_Ready <= 1'b1;
                            state      <= ST_END;
                        end
                    end
                end
                ST_LOW: begin
                    if (tmrTc) begin
                        TCK   <= 1'b1;
                        state <= ST_HIGH;
                    end
                end
                ST_END: begin
                    if (iTxD_Start) begin
                        // Back-to-back byte: TCS stays low.
                        txShift <= {1'b0, iTxD_DATA[7:1]};
                        TDI     <= iTxD_DATA[0];
                        bitCnt  <= '0;
                        state   <= ST_SETUP;
                    end else begin
                        TCS   <= 1'b1;
                        TDI   <= 1'b0;
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tmrTc) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_host_link.sv
// -----------------------------------------------------------------------------
// tb_jtag_host_link
// Self-checking bench for jtag_host_link. A device model on the JTAG pins
// captures TDI on rising TCK and drives response bits on TDO; a timeline model
// predicts every rising TCK cycle and every Done pulse from the accept cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jtag_host_link;

    localparam int H        = 4;
    localparam int GAPC     = 2;
    localparam int BYTE_CYC = 16 * H + 1;

    logic       iCLK = 1'b0;
    logic       iRST_n;
    logic [7:0] iTxD_DATA = 8'h00;
    logic       iTxD_Start = 1'b0;
    logic       oTxD_Ready;
    logic       oTxD_Done;
    logic [7:0] oRxD_DATA;
    logic       oRxD_Ready;
    logic       TCK;
    logic       TCS;
    logic       TDI;
    logic       TDO;
    bit         loopOn = 1'b0;
`ifdef JTAG_HOST_LOOPBACK_EN
    logic       iLoop;
    assign iLoop = loopOn;
`endif

    jtag_host_link #(
        .CLK_DIV (H),
        .CS_GAP  (GAPC)
    ) dut (
        .iCLK       (iCLK),
        .iRST_n     (iRST_n),
        .iTxD_DATA  (iTxD_DATA),
        .iTxD_Start (iTxD_Start),
        .oTxD_Ready (oTxD_Ready),
        .oTxD_Done  (oTxD_Done),
        .oRxD_DATA  (oRxD_DATA),
        .oRxD_Ready (oRxD_Ready),
        .TCK        (TCK),
        .TCS        (TCS),
        .TDI        (TDI),
`ifdef JTAG_HOST_LOOPBACK_EN
        .iLoop      (iLoop),
`endif
        .TDO        (TDO)
    );

    always #5 iCLK = ~iCLK;

    int nCompared   = 0;
    int nMismatched = 0;
    int cyc         = 0;

    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- device model ----------------
    logic [7:0] respArr [256];
    logic [7:0] devByteCnt = 8'd0;
    logic [2:0] devBitIdx  = 3'd0;
    logic [7:0] devShift   = 8'h00;
    int         devBits    = 0;
    int         devRiseCnt = 0;
    bit         tieHigh    = 1'b0;
    logic [7:0] devExpQ [$];

    assign TDO = tieHigh ? 1'b1 : respArr[devByteCnt][devBitIdx];

    always @(negedge TCS) devBitIdx = 3'd0;
    always @(posedge TCS) devBits = 0;

    // Next response bit is presented after each falling TCK.
    always @(negedge TCK) begin
        if (TCS === 1'b0) begin
            if (devBitIdx == 3'd7) devByteCnt = devByteCnt + 8'd1;
            devBitIdx = devBitIdx + 3'd1;
        end
    end

    always @(posedge TCK) begin
        if (TCS === 1'b0) begin
            devShift = {TDI, devShift[7:1]};
            devBits++;
            devRiseCnt++;
            if (devBits == 8) begin
                devBits = 0;
                if (devExpQ.size() == 0) checkEq("devExtraByte", 32'(devExpQ.size()), 32'(1));
                else checkEq("devRxByte", 32'(devShift), 32'(devExpQ.pop_front()));
            end
        end
    end

    // ---------------- timeline model + monitor ----------------
    int         riseQ [$];
    int         doneCycQ [$];
    logic [7:0] doneRxQ [$];
    int         doneLog [$];
    int         tcsLog [$];
    int         tcsRiseCnt = 0;
    int         tcsHighRun = 0;
    int         lastTdiChg = 0;
    logic       prevTck = 1'b0;
    logic       prevTcs = 1'b1;
    logic       prevTdi = 1'b0;
    int         xferIdx = 0;

    always @(negedge iCLK) begin
        bit expDone;
        if (TDI !== prevTdi) begin
            checkEq("tdiChangeTckLow", 32'(TCK), 32'(0));
            lastTdiChg = cyc;
        end
        if (TCK === 1'b1 && prevTck === 1'b0) begin
            checkEq("tdiSetup", 32'((cyc - lastTdiChg) >= H), 32'(1));
            checkEq("tcsAtRise", 32'(TCS), 32'(0));
            if (riseQ.size() == 0) checkEq("riseUnexpected", 32'(TCK), 32'(0));
            else checkEq("riseCycle", 32'(cyc), 32'(riseQ.pop_front()));
        end
        if (riseQ.size() > 0 && riseQ[0] < cyc)
            checkEq("riseMissing", 32'(cyc), 32'(riseQ.pop_front()));
        if (TCS === 1'b1 && prevTcs === 1'b0) tcsRiseCnt++;
        if (TCS === 1'b0 && prevTcs === 1'b1)
            checkEq("csGapLen", 32'(tcsHighRun >= GAPC), 32'(1));
        tcsHighRun = (TCS === 1'b1) ? tcsHighRun + 1 : 0;

        expDone = (doneCycQ.size() > 0) && (doneCycQ[0] == cyc);
        if (oTxD_Done === 1'b1 || expDone) begin
            checkEq("donePulse", 32'(oTxD_Done), 32'(expDone));
            if (expDone) begin
                checkEq("rxReadyPulse", 32'(oRxD_Ready), 32'(1));
                checkEq("rxData", 32'(oRxD_DATA), 32'(doneRxQ[0]));
                void'(doneCycQ.pop_front());
                void'(doneRxQ.pop_front());
                doneLog.push_back(cyc);
                tcsLog.push_back(tcsRiseCnt);
            end
        end
        if (oRxD_Ready === 1'b1 && oTxD_Done !== 1'b1)
            checkEq("rxReadyAlone", 32'(oRxD_Ready), 32'(0));
        if (doneCycQ.size() > 0 && doneCycQ[0] < cyc) begin
            checkEq("doneMissing", 32'(cyc), 32'(doneCycQ.pop_front()));
            void'(doneRxQ.pop_front());
        end
        prevTck = TCK;
        prevTcs = TCS;
        prevTdi = TDI;
    end

    // Request one byte; hold keeps iTxD_Start high after the accept.
    task automatic doXfer(input logic [7:0] data, input logic [7:0] resp, input bit hold);
        int waitCnt;
        int acc;
        logic [7:0] expRx;
        @(negedge iCLK);
        respArr[xferIdx % 256] = resp;
        iTxD_DATA  = data;
        iTxD_Start = 1'b1;
        waitCnt = 0;
        while (oTxD_Ready !== 1'b1 && waitCnt < 4 * BYTE_CYC) begin
            @(negedge iCLK);
            waitCnt++;
        end
        if (oTxD_Ready !== 1'b1) begin
            checkEq("readyTimeout", 32'(oTxD_Ready), 32'(1));
            iTxD_Start = 1'b0;
            return;
        end
`ifdef JTAG_HOST_LOOPBACK_EN
        expRx = loopOn ? data : (tieHigh ? 8'hFF : resp);
`else
        expRx = tieHigh ? 8'hFF : resp;
`endif
        acc = cyc;
        for (int k = 0; k < 8; k++) riseQ.push_back(acc + H + 1 + 2 * k * H);
        doneCycQ.push_back(acc + BYTE_CYC);
        doneRxQ.push_back(expRx);
        devExpQ.push_back(data);
        xferIdx++;
        @(negedge iCLK);
        if (!hold) iTxD_Start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((doneCycQ.size() > 0 || riseQ.size() > 0) && n < 4 * BYTE_CYC) begin
            @(negedge iCLK);
            n++;
        end
        checkEq("drainTimeout", 32'(doneCycQ.size() + riseQ.size()), 32'(0));
        repeat (GAPC + 3) @(negedge iCLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        for (int i = 0; i < 256; i++) respArr[i] = 8'h00;
        iRST_n = 1'b0;

        // Reset held, then released and idle.
        repeat (5) @(negedge iCLK);
        checkEq("rstTcs", 32'(TCS), 32'(1));
        checkEq("rstTck", 32'(TCK), 32'(0));
        checkEq("rstReady", 32'(oTxD_Ready), 32'(1));
        iRST_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge iCLK);
            checkEq("idleTcs", 32'(TCS), 32'(1));
            checkEq("idleTck", 32'(TCK), 32'(0));
            checkEq("idleTdi", 32'(TDI), 32'(0));
            checkEq("idleReady", 32'(oTxD_Ready), 32'(1));
            checkEq("idleDone", 32'(oTxD_Done), 32'(0));
            checkEq("idleRxReady", 32'(oRxD_Ready), 32'(0));
            checkEq("idleRxData", 32'(oRxD_DATA), 32'(0));
        end

        // Single byte 0xA5 against response 0x3C.
        doXfer(8'hA5, 8'h3C, 1'b0);
        drain();
        checkEq("a5RxHeld", 32'(oRxD_DATA), 32'(8'h3C));
        checkEq("a5TcsIdle", 32'(TCS), 32'(1));

        // Back-to-back 0x01 then 0x80 with start held.
        doXfer(8'h01, 8'h7E, 1'b1);
        doXfer(8'h80, 8'h81, 1'b0);
        drain();
        n = doneLog.size();
        checkEq("b2bPeriod", 32'(doneLog[n-1] - doneLog[n-2]), 32'(BYTE_CYC));
        checkEq("b2bTcsLow", 32'(tcsLog[n-1] - tcsLog[n-2]), 32'(0));

        // Start pulsed with 0xFF while a byte is in flight.
        doXfer(8'hA0, 8'h5C, 1'b0);
        repeat (20) @(negedge iCLK);
        iTxD_DATA  = 8'hFF;
        iTxD_Start = 1'b1;
        @(negedge iCLK);
        iTxD_Start = 1'b0;
        n = doneLog.size();
        drain();
        checkEq("busyOneDone", 32'(doneLog.size() - n), 32'(1));

        // Reset after the 4th rising TCK edge, then a clean 0x55.
        base = devRiseCnt;
        doXfer(8'h96, 8'hC3, 1'b0);
        n = 0;
        while (devRiseCnt < base + 4 && n < 2 * BYTE_CYC) begin
            @(negedge iCLK);
            n++;
        end
        checkEq("abortReached4", 32'(devRiseCnt - base), 32'(4));
        #2 iRST_n = 1'b0;
        #1;
        checkEq("abortTcs", 32'(TCS), 32'(1));
        checkEq("abortTck", 32'(TCK), 32'(0));
        checkEq("abortTdi", 32'(TDI), 32'(0));
        checkEq("abortReady", 32'(oTxD_Ready), 32'(1));
        riseQ.delete();
        doneCycQ.delete();
        doneRxQ.delete();
        void'(devExpQ.pop_back());
        xferIdx--;
        repeat (5) @(negedge iCLK);
        iRST_n = 1'b1;
        doXfer(8'h55, 8'hE1, 1'b0);
        drain();

        // Loopback with TDO pin tied high.
        tieHigh = 1'b1;
        loopOn  = 1'b1;
        doXfer(8'h5A, 8'h00, 1'b0);
        drain();
        tieHigh = 1'b0;
        loopOn  = 1'b0;

        // Randomized traffic: held, drained, or queued-while-busy requests.
        for (int i = 0; i < 24; i++) begin
            int mode;
            logic [7:0] d;
            logic [7:0] r;
            d = 8'($urandom);
            r = 8'($urandom);
            mode = int'($urandom_range(0, 2));
            doXfer(d, r, mode == 0);
            if (mode == 1) begin
                drain();
                repeat ($urandom_range(0, 5)) @(negedge iCLK);
            end
        end
        iTxD_Start = 1'b0;
        drain();
        checkEq("devQueueEmpty", 32'(devExpQ.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
